// File: rtl/dtcm_arbiter.sv
// DTCM arbiter: shares the single-port DTCM SRAM between the core LSU and an
// external slave port. The LSU has fixed priority. A starvation counter forces
// an external grant after STARVE_LIMIT consecutive denials. External read data
// is held in a one-entry buffer while the external side back-pressures.
module dtcm_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // LSU port
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_we,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [31:0]       lsu_req_wdata,
  input  logic [3:0]        lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [31:0]       lsu_rsp_rdata,
  // External port
  input  logic              ext_req_valid,
  output logic              ext_req_ready,
  input  logic              ext_req_we,
  input  logic [ADDR_W-1:0] ext_req_addr,
  input  logic [31:0]       ext_req_wdata,
  input  logic [3:0]        ext_req_wmask,
  output logic              ext_rsp_valid,
  input  logic              ext_rsp_ready,
  output logic [31:0]       ext_rsp_rdata,
  // SRAM
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wmask,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        lsu_inflight_q, lsu_we_q;
  logic        ext_inflight_q, ext_we_q;
  logic        buf_valid_q;
  logic [31:0] buf_data_q;

  logic        ext_ok, ext_starved, ext_win, lsu_go;
  logic [31:0] ext_rd;

  // Byte-offset bits are never used for a word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lsu_req_addr[1:0], ext_req_addr[1:0]};

  // Arbitration and ready generation; all grants are suppressed during reset.
  always_comb begin
    ext_ok        = ~buf_valid_q & ~(ext_inflight_q & ~ext_rsp_ready);
    ext_starved   = ext_req_valid & ext_ok & (starve_q == StarveMax);
    ext_win       = ~rst & ext_req_valid & ext_ok & (ext_starved | ~lsu_req_valid);
    // The idle LSU grant is offered only when external is not asking at all.
    lsu_req_ready = ~rst & (lsu_req_valid ? ~ext_starved : ~ext_req_valid);
    ext_req_ready = ext_win;
    lsu_go        = lsu_req_valid & lsu_req_ready;
  end

  // SRAM drive from whichever port won; all zero when there is no access.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (lsu_go) begin
      ram_cs    = 1'b1;
      ram_we    = lsu_req_we;
      ram_addr  = lsu_req_addr[ADDR_W-1:2];
      ram_wdata = lsu_req_wdata;
      ram_wmask = lsu_req_wmask;
    end else if (ext_win) begin
      ram_cs    = 1'b1;
      ram_we    = ext_req_we;
      ram_addr  = ext_req_addr[ADDR_W-1:2];
      ram_wdata = ext_req_wdata;
      ram_wmask = ext_req_wmask;
    end
  end

  // Starvation counter next state: counts only denials the external port could have taken.
  always_comb begin
    starve_d = starve_q;
    if (!ext_req_valid || ext_win) begin
      starve_d = '0;
    end else if (ext_ok && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Response outputs; writes return zero data.
  always_comb begin
    ext_rd        = ext_we_q ? 32'h0 : ram_rdata;
    lsu_rsp_valid = ~rst & lsu_inflight_q;
    lsu_rsp_rdata = (lsu_rsp_valid && !lsu_we_q) ? ram_rdata : 32'h0;
    ext_rsp_valid = ~rst & (buf_valid_q | ext_inflight_q);
    ext_rsp_rdata = 32'h0;
    if (!rst) begin
      if (buf_valid_q) begin
        ext_rsp_rdata = buf_data_q;
      end else if (ext_inflight_q) begin
        ext_rsp_rdata = ext_rd;
      end
    end
  end

  // In-flight ownership, starvation count and external response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q       <= '0;
      lsu_inflight_q <= 1'b0;
      lsu_we_q       <= 1'b0;
      ext_inflight_q <= 1'b0;
      ext_we_q       <= 1'b0;
      buf_valid_q    <= 1'b0;
      buf_data_q     <= '0;
    end else begin
      starve_q       <= starve_d;
      lsu_inflight_q <= lsu_go;
      lsu_we_q       <= lsu_go & lsu_req_we;
      ext_inflight_q <= ext_win;
      ext_we_q       <= ext_win & ext_req_we;
      // ext_ok blocks new grants while the buffer is full, so capture and drain never overlap.
      if (ext_inflight_q && !ext_rsp_ready) begin
        buf_valid_q <= 1'b1;
        buf_data_q  <= ext_rd;
      end else if (buf_valid_q && ext_rsp_ready) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dtcm_arbiter.md
Name: dtcm_arbiter

Overview:
Shares the single-port DTCM SRAM between two requesters: the core LSU (driven by the AGU's dtcm request, address, store data and store mask) and an external slave port (debug / system bus). Each cycle it grants at most one access and drives the SRAM. It routes the one-cycle-latency read data back to the owner. External responses are buffered when the external side back-pressures. The LSU has fixed priority, with a starvation counter guaranteeing external progress.

Parameters:
ADDR_W, 16, DTCM byte-address width; SRAM word address is addr[ADDR_W-1:2]
STARVE_LIMIT, 4, consecutive denied cycles of a pending external request after which external wins the next arbitration (range 1..15)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
lsu_req_valid  in  1  LSU access request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_we  in  1  1=store, 0=load
lsu_req_addr  in  ADDR_W  byte address (word-aligned by AGU)
lsu_req_wdata  in  32  store data
lsu_req_wmask  in  4  byte mask, bit=1 means byte NOT written (0000=word)
lsu_rsp_valid  out  1  LSU response (load data or store ack)
lsu_rsp_rdata  out  32  load data
ext_req_valid  in  1  external access request
ext_req_ready  out  1  external request accepted this cycle
ext_req_we  in  1  1=write
ext_req_addr  in  ADDR_W  byte address, bits [1:0] ignored
ext_req_wdata  in  32  write data
ext_req_wmask  in  4  same encoding as LSU
ext_rsp_valid  out  1  external response valid
ext_rsp_ready  in  1  external response accepted
ext_rsp_rdata  out  32  read data
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_addr  out  ADDR_W-2  SRAM word address
ram_wdata  out  32  SRAM write data
ram_wmask  out  4  SRAM byte mask, same encoding
ram_rdata  in  32  SRAM read data, valid the cycle after ram_cs & ~ram_we

Behaviour:
- Reset: all outputs 0, starve counter 0, in-flight owner cleared, ext buffer empty. Reset mid-operation drops any in-flight or buffered response; none is emitted after reset.
- ext_ok = buffer empty AND NOT (ext access in flight AND ext_rsp_ready=0).
- Arbitration is combinational in cycle t:
  - if ext_req_valid & ext_ok & starve_cnt==STARVE_LIMIT, grant ext;
  - else if lsu_req_valid, grant lsu;
  - else if ext_req_valid & ext_ok, grant ext.
- ready is asserted only to the granted port. lsu_req_ready may be 1 with lsu_req_valid=0 only when ext is not requesting (idle grant allowed, no SRAM access).
- Granted request drives ram_* the same cycle. ram_cs=valid&ready of the granted port; otherwise ram_cs=0 and the other ram_* outputs are 0.
- Starve counter:
  - increments, saturating at STARVE_LIMIT, when ext_req_valid & ext_ok & lsu wins;
  - clears on ext grant or when ext_req_valid=0;
  - holds while ext_ok=0.
- Response, latency 1:
  - every granted access (read or write) produces exactly one response in cycle t+1 to its owner;
  - rdata=ram_rdata for reads, 0 for writes.
- lsu_rsp_valid has no back-pressure.
- External response:
  - ext_rsp_valid is asserted in t+1 with ram_rdata.
  - If ext_rsp_ready=0 in t+1, data is captured into the 1-entry buffer. ext_rsp_valid stays 1 from the buffer, with stable data, until ext_rsp_ready=1; the buffer then empties.
  - Back-to-back ext grants are allowed when ext_rsp_ready=1 in the in-flight cycle.
- Simultaneous: LSU and ext both valid, starve_cnt<limit → LSU granted, ext held (ready=0, request must remain stable).

Test Plan:
- LSU read addr 0x0010, SRAM word 4 = 0xDEADBEEF → ram_cs=1, ram_addr=4 cycle t; lsu_rsp_valid=1, rdata=0xDEADBEEF cycle t+1.
- LSU store addr 0x0008, wdata 0x000000AB, wmask 1110 → ram_we=1, ram_addr=2, ram_wmask=1110; lsu_rsp_valid=1, rdata=0 next cycle.
- LSU and ext both valid continuously, STARVE_LIMIT=4 → 4 LSU grants, then ext granted on the 5th cycle, counter back to 0.
- Ext read with ext_rsp_ready=0 for 3 cycles after issue → ext_rsp_valid held 3+ cycles with stable data; ext_req_ready=0 throughout; accepted when ready=1, then a new ext grant is possible.
- Ext back-to-back reads to words 1,2,3 with ext_rsp_ready=1, no LSU traffic → one grant per cycle, responses in order, one cycle later each.
- Assert rst while an ext response is buffered → next cycle all outputs 0; no ext_rsp_valid afterwards.
